// File: rtl/mmio_pkg.sv
// Shared types and constants for the 8-bit MMIO bus and its initiator.
//   size_e   : LSU access size encoding (3 is illegal and has no enumerator)
//   state_e  : bus master FSM states
//   req_t    : request payload captured from the LSU on accept
//   load_extend : zero/sign extension of a little-endian load result
package mmio_pkg;

    localparam int unsigned MMIO_DATA_W = 8;
    localparam int unsigned MMIO_ADDR_W = 32;
    localparam int unsigned LSU_DATA_W  = 32;
    localparam int unsigned LANES       = LSU_DATA_W / MMIO_DATA_W;

    localparam logic [MMIO_ADDR_W-1:0] MMIO_GPIO_BASE = 32'h2000_0000;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BEAT = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef struct packed {
        logic                   we;
        logic [1:0]             size;
        logic                   uns;
        logic [MMIO_ADDR_W-1:0] addr;
        logic [LSU_DATA_W-1:0]  wdata;
    } req_t;

    // Extend the low byte/half of a gathered load from its top bit unless unsigned.
    function automatic logic [LSU_DATA_W-1:0] load_extend(
        input logic [LSU_DATA_W-1:0] raw,
        input logic [1:0]            size,
        input logic                  uns
    );
        logic [LSU_DATA_W-1:0] res;
        case (size)
            SZ_B:    res = {{24{raw[7]  & ~uns}}, raw[7:0]};
            SZ_H:    res = {{16{raw[15] & ~uns}}, raw[15:0]};
            default: res = raw;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/mmio_access_check.sv
// Combinational legality check of an LSU request before any beat is issued.
//   size_i     : access size (0=byte, 1=half, 2=word, 3=illegal)
//   addr_i     : byte address of the access
//   nbeats_c_o : number of byte beats the access needs (1/2/4)
//   err_c_o    : access is misaligned or illegal; with MMIO_BUS_MASTER_WINDOW_CHECK_EN
//                defined, also set when any byte falls outside [MMIO_BASE, MMIO_BASE+MMIO_SIZE)
module mmio_access_check
    import mmio_pkg::*;
#(
    parameter logic [31:0] MMIO_BASE = MMIO_GPIO_BASE,
    parameter logic [31:0] MMIO_SIZE = 32'h0000_1000
) (
    input  logic [1:0]  size_i,
    input  logic [31:0] addr_i,
    output logic [2:0]  nbeats_c_o,
    output logic        err_c_o
);

`ifdef MMIO_BUS_MASTER_WINDOW_CHECK_EN
    localparam bit WIN_EN = 1'b1;
`else
    localparam bit WIN_EN = 1'b0;
`endif

    // 33-bit bounds so a window ending at 2^32 and a wrapping access both compare correctly.
    localparam logic [32:0] WIN_LO = {1'b0, MMIO_BASE};
    localparam logic [32:0] WIN_HI = {1'b0, MMIO_BASE} + {1'b0, MMIO_SIZE};

    logic [2:0]  nbeats;
    logic        misalign;
    logic [32:0] end_excl;
    logic        out_of_win;

    // Beat count and alignment per size.
    always_comb begin
        nbeats   = 3'd1;
        misalign = 1'b0;
        case (size_i)
            SZ_B: begin
                nbeats   = 3'd1;
                misalign = 1'b0;
            end
            SZ_H: begin
                nbeats   = 3'd2;
                misalign = addr_i[0];
            end
            SZ_W: begin
                nbeats   = 3'd4;
                misalign = |addr_i[1:0];
            end
            default: begin
                nbeats   = 3'd1;
                misalign = 1'b1;
            end
        endcase
    end

    // Window containment of every byte of the access.
    always_comb begin
        end_excl   = {1'b0, addr_i} + 33'(nbeats);
        out_of_win = ({1'b0, addr_i} < WIN_LO) || (end_excl > WIN_HI);
    end

    assign nbeats_c_o = nbeats;
    assign err_c_o    = misalign | (WIN_EN & out_of_win);

endmodule

// File: rtl/mmio_bus_master.sv
// CPU-side initiator for the 8-bit MMIO bus. Splits one LSU load/store into 1/2/4
// little-endian byte beats, one per cycle, and reports completion with a done pulse.
// Optional build macro: MMIO_BUS_MASTER_WINDOW_CHECK_EN (out-of-window requests error).
//   i_clk, i_rstn       : clock, asynchronous active-low reset
//   i_req/i_we/i_size/i_unsigned/i_addr/i_wdata : LSU request, accepted when i_req && o_ready
//   o_ready             : high only while idle
//   o_done/o_err/o_rdata: completion pulse, error flag and load result
//   o_mmio_addr/o_mmio_data_out/o_mmio_we/o_mmio_re : beat outputs, zero outside beats
//   i_mmio_data_in      : responder read byte, valid in the beat cycle
module mmio_bus_master
    import mmio_pkg::*;
#(
    parameter logic [31:0] MMIO_BASE = MMIO_GPIO_BASE,
    parameter logic [31:0] MMIO_SIZE = 32'h0000_1000
) (
    input  logic        i_clk,
    input  logic        i_rstn,
    input  logic        i_req,
    input  logic        i_we,
    input  logic [1:0]  i_size,
    input  logic        i_unsigned,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic        o_ready,
    output logic        o_done,
    output logic        o_err,
    output logic [31:0] o_rdata,
    output logic [31:0] o_mmio_addr,
    output logic [7:0]  o_mmio_data_out,
    input  logic [7:0]  i_mmio_data_in,
    output logic        o_mmio_we,
    output logic        o_mmio_re
);

    state_e                          state_q, state_d;
    req_t                            req_q, req_d;
    logic [1:0]                      idx_q, idx_d;
    logic [2:0]                      nbeats_q, nbeats_d;
    logic [LANES-1:0][MMIO_DATA_W-1:0] rbytes_q, rbytes_d;
    logic                            ready_q, ready_d;
    logic                            done_q, done_d;
    logic                            err_q, err_d;
    logic [LSU_DATA_W-1:0]           rdata_q, rdata_d;
    logic [MMIO_ADDR_W-1:0]          mmio_addr_q, mmio_addr_d;
    logic [MMIO_DATA_W-1:0]          mmio_data_q, mmio_data_d;
    logic                            mmio_we_q, mmio_we_d;
    logic                            mmio_re_q, mmio_re_d;

    logic [2:0] chk_nbeats_c;
    logic       chk_err_c;
    logic [1:0] nxt_idx_c;
    logic       last_beat_c;

    // Legality and beat count of the incoming request.
    mmio_access_check #(
        .MMIO_BASE (MMIO_BASE),
        .MMIO_SIZE (MMIO_SIZE)
    ) u_access_check (
        .size_i     (i_size),
        .addr_i     (i_addr),
        .nbeats_c_o (chk_nbeats_c),
        .err_c_o    (chk_err_c)
    );

    assign nxt_idx_c   = idx_q + 2'd1;
    assign last_beat_c = ({1'b0, idx_q} == (nbeats_q - 3'd1));

    // State and registered outputs.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q     <= ST_IDLE;
            req_q       <= '0;
            idx_q       <= '0;
            nbeats_q    <= '0;
            rbytes_q    <= '0;
            ready_q     <= 1'b1;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            rdata_q     <= '0;
            mmio_addr_q <= '0;
            mmio_data_q <= '0;
            mmio_we_q   <= 1'b0;
            mmio_re_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            idx_q       <= idx_d;
            nbeats_q    <= nbeats_d;
            rbytes_q    <= rbytes_d;
            ready_q     <= ready_d;
            done_q      <= done_d;
            err_q       <= err_d;
            rdata_q     <= rdata_d;
            mmio_addr_q <= mmio_addr_d;
            mmio_data_q <= mmio_data_d;
            mmio_we_q   <= mmio_we_d;
            mmio_re_q   <= mmio_re_d;
        end
    end

    // Next state; outputs are computed one cycle ahead so each beat appears registered.
    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        idx_d       = idx_q;
        nbeats_d    = nbeats_q;
        rbytes_d    = rbytes_q;
        err_d       = err_q;
        ready_d     = 1'b0;
        done_d      = 1'b0;
        rdata_d     = '0;
        mmio_addr_d = '0;
        mmio_data_d = '0;
        mmio_we_d   = 1'b0;
        mmio_re_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                ready_d = 1'b1;
                if (i_req) begin
                    req_d    = '{we: i_we, size: i_size, uns: i_unsigned,
                                 addr: i_addr, wdata: i_wdata};
                    idx_d    = '0;
                    nbeats_d = chk_nbeats_c;
                    rbytes_d = '0;
                    err_d    = chk_err_c;
                    ready_d  = 1'b0;
                    if (chk_err_c) begin
                        // Rejected requests skip the bus entirely.
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d     = ST_BEAT;
                        mmio_addr_d = i_addr;
                        mmio_data_d = i_we ? i_wdata[MMIO_DATA_W-1:0] : '0;
                        mmio_we_d   = i_we;
                        mmio_re_d   = ~i_we;
                    end
                end
            end

            ST_BEAT: begin
                if (!req_q.we) begin
                    rbytes_d[idx_q] = i_mmio_data_in;
                end
                idx_d = nxt_idx_c;
                if (last_beat_c) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    rdata_d = req_q.we ? '0 : load_extend(rbytes_d, req_q.size, req_q.uns);
                end else begin
                    mmio_addr_d = req_q.addr + 32'(nxt_idx_c);
                    mmio_data_d = req_q.we ? req_q.wdata[{nxt_idx_c, 3'b000} +: MMIO_DATA_W] : '0;
                    mmio_we_d   = req_q.we;
                    mmio_re_d   = ~req_q.we;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
                ready_d = 1'b1;
                err_d   = 1'b0;
            end

            default: begin
                state_d = ST_IDLE;
                ready_d = 1'b1;
                err_d   = 1'b0;
            end
        endcase
    end

    assign o_ready         = ready_q;
    assign o_done          = done_q;
    assign o_err           = err_q;
    assign o_rdata         = rdata_q;
    assign o_mmio_addr     = mmio_addr_q;
    assign o_mmio_data_out = mmio_data_q;
    assign o_mmio_we       = mmio_we_q;
    assign o_mmio_re       = mmio_re_q;

endmodule

// File: tb/tb_mmio_bus_master.sv
// Self-checking bench for mmio_bus_master: a byte-memory responder, a scoreboard of
// expected beats/completions keyed by cycle, and one task per scenario.
module tb_mmio_bus_master;

    logic        i_clk = 1'b0;
    logic        i_rstn = 1'b0;
    logic        i_req = 1'b0;
    logic        i_we = 1'b0;
    logic [1:0]  i_size = 2'd0;
    logic        i_unsigned = 1'b0;
    logic [31:0] i_addr = 32'h0;
    logic [31:0] i_wdata = 32'h0;
    logic        o_ready, o_done, o_err;
    logic [31:0] o_rdata, o_mmio_addr;
    logic [7:0]  o_mmio_data_out;
    logic [7:0]  i_mmio_data_in;
    logic        o_mmio_we, o_mmio_re;

    int          n_checks = 0;
    int          n_fail = 0;
    int unsigned cyc = 0;

    typedef struct {
        int unsigned cyc;
        logic        we;
        logic [31:0] addr;
        logic [7:0]  data;
    } beat_t;

    typedef struct {
        int unsigned cyc;
        logic        err;
        logic [31:0] rdata;
    } done_t;

    typedef struct {
        logic        we;
        logic [1:0]  sz;
        logic        uns;
        logic [31:0] a;
        logic [31:0] wd;
        logic        err;
        logic [31:0] rd;
    } vec_t;

    beat_t exp_beats[$];
    done_t exp_done[$];

    logic [7:0] mem [0:4095];

    mmio_bus_master dut (
        .i_clk           (i_clk),
        .i_rstn          (i_rstn),
        .i_req           (i_req),
        .i_we            (i_we),
        .i_size          (i_size),
        .i_unsigned      (i_unsigned),
        .i_addr          (i_addr),
        .i_wdata         (i_wdata),
        .o_ready         (o_ready),
        .o_done          (o_done),
        .o_err           (o_err),
        .o_rdata         (o_rdata),
        .o_mmio_addr     (o_mmio_addr),
        .o_mmio_data_out (o_mmio_data_out),
        .i_mmio_data_in  (i_mmio_data_in),
        .o_mmio_we       (o_mmio_we),
        .o_mmio_re       (o_mmio_re)
    );

    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) cyc <= cyc + 1;

    // Responder: combinational read, write committed at the clock edge.
    assign i_mmio_data_in = o_mmio_re ? mem[o_mmio_addr[11:0]] : 8'h00;
    always @(posedge i_clk) begin
        if (o_mmio_we) mem[o_mmio_addr[11:0]] <= o_mmio_data_out;
    end

    // Scoreboard: every beat and completion must match the next expected entry.
    always @(negedge i_clk) begin : monitor
        beat_t eb;
        done_t ed;
        logic [7:0] obs;
        if (i_rstn) begin
            if (o_mmio_we || o_mmio_re) begin
                n_checks++;
                obs = o_mmio_we ? o_mmio_data_out : i_mmio_data_in;
                if (exp_beats.size() == 0) begin
                    n_fail++;
                    $display("FAIL beat: unexpected beat cyc=%0d we=%b re=%b addr=%h data=%h",
                             cyc, o_mmio_we, o_mmio_re, o_mmio_addr, obs);
                end else begin
                    eb = exp_beats.pop_front();
                    if (cyc !== eb.cyc || o_mmio_we !== eb.we || o_mmio_re !== !eb.we ||
                        o_mmio_addr !== eb.addr || obs !== eb.data) begin
                        n_fail++;
                        $display("FAIL beat: got cyc=%0d we=%b re=%b addr=%h data=%h, want cyc=%0d we=%b addr=%h data=%h",
                                 cyc, o_mmio_we, o_mmio_re, o_mmio_addr, obs, eb.cyc, eb.we, eb.addr, eb.data);
                    end
                end
            end else begin
                n_checks++;
                if (o_mmio_addr !== 32'h0 || o_mmio_data_out !== 8'h0) begin
                    n_fail++;
                    $display("FAIL bus_idle: cyc=%0d addr=%h data=%h, want 0", cyc, o_mmio_addr, o_mmio_data_out);
                end
            end
            if (o_done) begin
                n_checks++;
                if (exp_done.size() == 0) begin
                    n_fail++;
                    $display("FAIL done: unexpected done cyc=%0d err=%b rdata=%h", cyc, o_err, o_rdata);
                end else begin
                    ed = exp_done.pop_front();
                    if (cyc !== ed.cyc || o_err !== ed.err || o_rdata !== ed.rdata) begin
                        n_fail++;
                        $display("FAIL done: got cyc=%0d err=%b rdata=%h, want cyc=%0d err=%b rdata=%h",
                                 cyc, o_err, o_rdata, ed.cyc, ed.err, ed.rdata);
                    end
                end
            end
        end
    end

    // Present a request and wait for it to be accepted; t0 is the accept cycle.
    task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [31:0] wd, input bit hold,
                         output int unsigned t0);
        bit got = 1'b0;
        t0 = 0;
        i_req = 1'b1; i_we = we; i_size = sz; i_unsigned = uns; i_addr = a; i_wdata = wd;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge i_clk);
            if (o_ready === 1'b1) begin
                t0  = cyc;
                got = 1'b1;
            end
        end
        @(posedge i_clk);
        #1;
        if (!hold) i_req = 1'b0;
        if (!got) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept_timeout: o_ready=%b addr=%h, want o_ready=1", o_ready, a);
        end
    endtask

    // Push the beats and completion a request accepted at t0 must produce.
    task automatic expect_txn(input int unsigned t0, input vec_t v);
        beat_t       b;
        done_t       d;
        logic [31:0] ak;
        int unsigned nb;
        if (v.err) begin
            d.cyc = t0 + 1; d.err = 1'b1; d.rdata = 32'h0;
            exp_done.push_back(d);
        end else begin
            nb = (v.sz == 2'd0) ? 1 : (v.sz == 2'd1) ? 2 : 4;
            for (int k = 0; k < int'(nb); k++) begin
                ak     = v.a + 32'(k);
                b.cyc  = t0 + 1 + k;
                b.we   = v.we;
                b.addr = ak;
                b.data = v.we ? v.wd[8*k +: 8] : mem[ak[11:0]];
                exp_beats.push_back(b);
            end
            d.cyc = t0 + nb + 1; d.err = 1'b0; d.rdata = v.we ? 32'h0 : v.rd;
            exp_done.push_back(d);
        end
    endtask

    task automatic test_reset();
        i_rstn = 1'b0;
        repeat (3) @(posedge i_clk);
        #1;
        n_checks++;
        if (o_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready: got %b, want 1", o_ready);
        end
        n_checks++;
        if ({o_done, o_err, o_mmio_we, o_mmio_re, o_rdata, o_mmio_addr, o_mmio_data_out} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: done=%b err=%b we=%b re=%b rdata=%h addr=%h data=%h, want all 0",
                     o_done, o_err, o_mmio_we, o_mmio_re, o_rdata, o_mmio_addr, o_mmio_data_out);
        end
        @(negedge i_clk);
        i_rstn = 1'b1;
        @(posedge i_clk);
        #1;
    endtask

    task automatic test_word_store();
        vec_t        v;
        int unsigned t0;
        v = '{we: 1'b1, sz: 2'd2, uns: 1'b0, a: 32'h2000_0000, wd: 32'hA1B2_C3D4, err: 1'b0, rd: 32'h0};
        issue(v.we, v.sz, v.uns, v.a, v.wd, 1'b0, t0);
        expect_txn(t0, v);
        for (int i = 0; i < 20 && exp_done.size() != 0; i++) @(posedge i_clk);
        #1;
        n_checks++;
        if (exp_done.size() != 0 || exp_beats.size() != 0) begin
            n_fail++;
            $display("FAIL word_store_drain: pending beats=%0d dones=%0d, want 0", exp_beats.size(), exp_done.size());
        end
        n_checks++;
        if ({mem[3], mem[2], mem[1], mem[0]} !== 32'hA1B2_C3D4) begin
            n_fail++;
            $display("FAIL word_store_mem: got %h, want a1b2c3d4", {mem[3], mem[2], mem[1], mem[0]});
        end
    endtask

    task automatic test_loads();
        vec_t        vl [6];
        int unsigned t0;
        mem[4] <= 8'h80;
        mem[8] <= 8'h34; mem[9] <= 8'h92;
        mem[12] <= 8'h78; mem[13] <= 8'h56; mem[14] <= 8'h34; mem[15] <= 8'h12;
        @(posedge i_clk);
        #1;
        vl[0] = '{we: 1'b0, sz: 2'd0, uns: 1'b0, a: 32'h2000_0004, wd: 32'h0, err: 1'b0, rd: 32'hFFFF_FF80};
        vl[1] = '{we: 1'b0, sz: 2'd0, uns: 1'b1, a: 32'h2000_0004, wd: 32'h0, err: 1'b0, rd: 32'h0000_0080};
        vl[2] = '{we: 1'b0, sz: 2'd1, uns: 1'b0, a: 32'h2000_0008, wd: 32'h0, err: 1'b0, rd: 32'hFFFF_9234};
        vl[3] = '{we: 1'b0, sz: 2'd1, uns: 1'b1, a: 32'h2000_0008, wd: 32'h0, err: 1'b0, rd: 32'h0000_9234};
        vl[4] = '{we: 1'b0, sz: 2'd2, uns: 1'b0, a: 32'h2000_000C, wd: 32'h0, err: 1'b0, rd: 32'h1234_5678};
        vl[5] = '{we: 1'b0, sz: 2'd0, uns: 1'b0, a: 32'h2000_000E, wd: 32'h0, err: 1'b0, rd: 32'h0000_0034};
        foreach (vl[j]) begin
            issue(vl[j].we, vl[j].sz, vl[j].uns, vl[j].a, vl[j].wd, 1'b0, t0);
            expect_txn(t0, vl[j]);
            for (int i = 0; i < 20 && exp_done.size() != 0; i++) @(posedge i_clk);
            #1;
            n_checks++;
            if (exp_done.size() != 0 || exp_beats.size() != 0) begin
                n_fail++;
                $display("FAIL load_drain[%0d]: pending beats=%0d dones=%0d, want 0", j, exp_beats.size(), exp_done.size());
            end
        end
    endtask

    task automatic test_errors();
        vec_t        ve [4];
        int unsigned t0;
        ve[0] = '{we: 1'b0, sz: 2'd1, uns: 1'b0, a: 32'h2000_0001, wd: 32'h0,         err: 1'b1, rd: 32'h0};
        ve[1] = '{we: 1'b1, sz: 2'd2, uns: 1'b0, a: 32'h2000_0002, wd: 32'hDEAD_BEEF, err: 1'b1, rd: 32'h0};
        ve[2] = '{we: 1'b0, sz: 2'd3, uns: 1'b0, a: 32'h2000_0000, wd: 32'h0,         err: 1'b1, rd: 32'h0};
        ve[3] = '{we: 1'b1, sz: 2'd1, uns: 1'b0, a: 32'h2000_0003, wd: 32'h0000_5555, err: 1'b1, rd: 32'h0};
        foreach (ve[j]) begin
            issue(ve[j].we, ve[j].sz, ve[j].uns, ve[j].a, ve[j].wd, 1'b0, t0);
            expect_txn(t0, ve[j]);
            for (int i = 0; i < 10 && exp_done.size() != 0; i++) @(posedge i_clk);
            #1;
            n_checks++;
            if (exp_done.size() != 0 || o_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL error_txn[%0d]: pending dones=%0d ready=%b, want 0 and 1", j, exp_done.size(), o_ready);
            end
        end
        n_checks++;
        if ({mem[3], mem[2], mem[1], mem[0]} !== 32'hA1B2_C3D4) begin
            n_fail++;
            $display("FAIL error_no_write: got %h, want a1b2c3d4", {mem[3], mem[2], mem[1], mem[0]});
        end
    endtask

    task automatic test_back_to_back();
        vec_t        va, vb, vw;
        int unsigned ta, tb;
        va = '{we: 1'b1, sz: 2'd0, uns: 1'b0, a: 32'h2000_0040, wd: 32'h0000_005A, err: 1'b0, rd: 32'h0};
        vb = '{we: 1'b1, sz: 2'd0, uns: 1'b0, a: 32'h2000_0041, wd: 32'h0000_00A5, err: 1'b0, rd: 32'h0};
        issue(va.we, va.sz, va.uns, va.a, va.wd, 1'b1, ta);
        expect_txn(ta, va);
        issue(vb.we, vb.sz, vb.uns, vb.a, vb.wd, 1'b0, tb);
        expect_txn(tb, vb);
        n_checks++;
        if (tb !== ta + 3) begin
            n_fail++;
            $display("FAIL b2b_accept: second accept at +%0d, want +3", tb - ta);
        end
        for (int i = 0; i < 20 && exp_done.size() != 0; i++) @(posedge i_clk);
        #1;
        n_checks++;
        if (exp_done.size() != 0 || {mem[65], mem[64]} !== 16'hA55A) begin
            n_fail++;
            $display("FAIL b2b_result: pending dones=%0d mem=%h, want 0 and a55a", exp_done.size(), {mem[65], mem[64]});
        end

        // A request pulsed mid-transfer must be dropped.
        vw = '{we: 1'b1, sz: 2'd2, uns: 1'b0, a: 32'h2000_0020, wd: 32'h0BAD_F00D, err: 1'b0, rd: 32'h0};
        issue(vw.we, vw.sz, vw.uns, vw.a, vw.wd, 1'b0, ta);
        expect_txn(ta, vw);
        @(posedge i_clk);
        #1;
        i_req = 1'b1; i_we = 1'b1; i_size = 2'd0; i_addr = 32'h2000_0030; i_wdata = 32'h77;
        @(negedge i_clk);
        n_checks++;
        if (o_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_ready: got %b, want 0", o_ready);
        end
        @(posedge i_clk);
        #1;
        i_req = 1'b0;
        for (int i = 0; i < 20 && exp_done.size() != 0; i++) @(posedge i_clk);
        repeat (3) @(posedge i_clk);
        #1;
        n_checks++;
        if (exp_done.size() != 0 || exp_beats.size() != 0 || mem[48] !== 8'h00) begin
            n_fail++;
            $display("FAIL busy_ignored: pending beats=%0d dones=%0d mem30=%h, want 0 0 00",
                     exp_beats.size(), exp_done.size(), mem[48]);
        end
    endtask

    task automatic test_reset_mid();
        beat_t       b;
        int unsigned t0;
        mem[16] <= 8'h00; mem[17] <= 8'h00; mem[18] <= 8'h00; mem[19] <= 8'h00;
        @(posedge i_clk);
        #1;
        issue(1'b1, 2'd2, 1'b0, 32'h2000_0010, 32'h1122_3344, 1'b0, t0);
        b = '{cyc: t0 + 1, we: 1'b1, addr: 32'h2000_0010, data: 8'h44};
        exp_beats.push_back(b);
        @(posedge i_clk);
        #1;
        i_rstn = 1'b0;
        #1;
        n_checks++;
        if (o_mmio_we !== 1'b0 || o_mmio_addr !== 32'h0 || o_done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_abort: we=%b addr=%h done=%b, want 0 0 0", o_mmio_we, o_mmio_addr, o_done);
        end
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        i_rstn = 1'b1;
        @(posedge i_clk);
        #1;
        n_checks++;
        if (o_ready !== 1'b1 || exp_beats.size() != 0) begin
            n_fail++;
            $display("FAIL reset_recover: ready=%b pending beats=%0d, want 1 and 0", o_ready, exp_beats.size());
        end
        repeat (6) @(posedge i_clk);
        #1;
        n_checks++;
        if ({mem[19], mem[18], mem[17], mem[16]} !== 32'h0000_0044) begin
            n_fail++;
            $display("FAIL reset_partial_write: got %h, want 00000044", {mem[19], mem[18], mem[17], mem[16]});
        end
    endtask

    task automatic test_window();
        vec_t        vw [3];
        int unsigned t0;
        mem[12'hFFC] <= 8'hEF; mem[12'hFFD] <= 8'hBE; mem[12'hFFE] <= 8'hAD; mem[12'hFFF] <= 8'hDE;
        @(posedge i_clk);
        #1;
        vw[0] = '{we: 1'b0, sz: 2'd2, uns: 1'b0, a: 32'h2000_0FFE, wd: 32'h0, err: 1'b1, rd: 32'h0};
`ifdef MMIO_BUS_MASTER_WINDOW_CHECK_EN
        vw[1] = '{we: 1'b0, sz: 2'd2, uns: 1'b0, a: 32'h1FFF_FFFC, wd: 32'h0, err: 1'b1, rd: 32'h0};
`else
        vw[1] = '{we: 1'b0, sz: 2'd2, uns: 1'b0, a: 32'h1FFF_FFFC, wd: 32'h0, err: 1'b0, rd: 32'hDEAD_BEEF};
`endif
        vw[2] = '{we: 1'b0, sz: 2'd2, uns: 1'b0, a: 32'h2000_0FFC, wd: 32'h0, err: 1'b0, rd: 32'hDEAD_BEEF};
        foreach (vw[j]) begin
            issue(vw[j].we, vw[j].sz, vw[j].uns, vw[j].a, vw[j].wd, 1'b0, t0);
            expect_txn(t0, vw[j]);
            for (int i = 0; i < 20 && exp_done.size() != 0; i++) @(posedge i_clk);
            #1;
            n_checks++;
            if (exp_done.size() != 0 || exp_beats.size() != 0) begin
                n_fail++;
                $display("FAIL window_drain[%0d]: pending beats=%0d dones=%0d, want 0", j, exp_beats.size(), exp_done.size());
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] <= 8'h00;
        test_reset();
        test_word_store();
        test_loads();
        test_errors();
        test_back_to_back();
        test_reset_mid();
        test_window();
        repeat (3) @(posedge i_clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

endmodule
